// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Build option DMEM_ARB_RR_EN (see dmem_arb_pick) selects round-robin vs fixed priority.
package dmem_arb_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t OWN0 = 2'd1;
  localparam state_t OWN1 = 2'd2;

  localparam int MID_W = 1;

  function automatic logic [63:0] word_idx(input logic [63:0] addr);
    return addr >> 2;
  endfunction
endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the two masters.
// DMEM_ARB_RR_EN defined: a tie goes to the port that did not win last; else port 0 wins ties.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0]       req,
  input  logic [MID_W-1:0] last_winner,
  output logic [1:0]       gnt
);
`ifdef DMEM_ARB_RR_EN
  always_comb begin
    gnt = req;
    if (&req) gnt = last_winner[0] ? 2'b01 : 2'b10;
  end
`else
  logic unused_lw;
  assign unused_lw = last_winner[0];
  assign gnt = req[0] ? 2'b01 : {req[1], 1'b0};
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for a single-port data memory with lockable bursts.
// Arbitration policy is chosen by DMEM_ARB_RR_EN inside dmem_arb_pick.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 32,
  parameter int LOCK_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [WIDTH-1:0]  m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [WIDTH-1:0]  m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [WIDTH-1:0]  m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [WIDTH-1:0]  m1_rdata,
  output logic              m1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [WIDTH-1:0]  mem_wd,
  input  logic [WIDTH-1:0]  mem_rd
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [1:0]             req, we, lock;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][WIDTH-1:0]  wdata;
  assign req   = {m1_req, m0_req};
  assign we    = {m1_we, m0_we};
  assign lock  = {m1_lock, m0_lock};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  state_t           state, state_nx;
  logic [CNT_W-1:0] lock_cnt, cnt_nx;
  logic [MID_W-1:0] last_winner;
  logic [1:0]       arb_gnt, gnt, rvalid, err;
  logic [1:0][WIDTH-1:0] rdata;
  logic             sel, own, in_range;
  logic [ADDR_W-1:0] widx;

  dmem_arb_pick u_pick (
    .req         (req),
    .last_winner (last_winner),
    .gnt         (arb_gnt)
  );

  // The owner of a locked burst shuts the other port out; reset kills grants immediately.
  always_comb begin
    gnt = arb_gnt;
    case (state)
      OWN0:    gnt = {1'b0, req[0]};
      OWN1:    gnt = {req[1], 1'b0};
      default: gnt = arb_gnt;
    endcase
    if (!rst_n) gnt = '0;
  end

  assign sel      = gnt[1];
  assign own      = (state == OWN1);
  assign widx     = ADDR_W'(word_idx(64'(addr[sel])));
  assign in_range = widx < ADDR_W'(ENTRIES);

  assign mem_a  = |gnt ? widx : '0;
  assign mem_wd = |gnt ? wdata[sel] : '0;
  assign mem_we = |gnt & we[sel] & in_range;

  // lock_cnt counts every beat of the burst, including the one that opened it.
  always_comb begin
    state_nx = state;
    cnt_nx   = lock_cnt;
    case (state)
      IDLE: begin
        if (|gnt && lock[sel] && LOCK_MAX > 1) begin
          state_nx = sel ? OWN1 : OWN0;
          cnt_nx   = CNT_W'(1);
        end
      end
      OWN0, OWN1: begin
        if (!gnt[own] || !lock[own] || lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = lock_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lock_cnt    <= '0;
      last_winner <= MID_W'(1);
      rvalid      <= '0;
      err         <= '0;
      rdata       <= '0;
    end else begin
      state    <= state_nx;
      lock_cnt <= cnt_nx;
      if (|gnt) last_winner <= MID_W'(sel);
      rvalid   <= gnt & ~we;
      err      <= gnt & {2{~in_range}};
      for (int k = 0; k < 2; k++)
        if (gnt[k] && !we[k]) rdata[k] <= in_range ? mem_rd : '0;
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid[0] & rst_n;
  assign m1_rvalid = rvalid[1] & rst_n;
  assign m0_err    = err[0];
  assign m1_err    = err[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];
endmodule
